// File: rtl/asyn_fifo_pkg.sv
`timescale 1ns/1ps
// asyn_fifo_pkg
// Shared helpers for the level-reporting dual-clock FIFO:
//   ptr_width(depth) - pointer width (address bits + one wrap bit)
//   bin2gray(b)      - binary to reflected gray code
//   gray2bin(g)      - reflected gray code to binary
// The code converters work on a 32-bit container. Callers zero-extend their
// pointer into it and take back the low bits. The unused upper bits stay
// zero through both conversions.
package asyn_fifo_pkg;

    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i + 1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/dual_port_RAM.sv
`timescale 1ns/1ps
// dual_port_RAM
// Simple dual-port storage. There is one write port on wclk and one read port
// on rclk. The read is registered, and rdata changes only on an enabled read.
//   wclk, wenc, waddr, wdata - write port
//   rclk, renc, raddr, rdata - read port (registered output, not reset)
module dual_port_RAM #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     wclk,
    input  logic                     wenc,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     rclk,
    input  logic                     renc,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge wclk) begin
        if (wenc) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge rclk) begin
        if (renc) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/fifo_ptr_sync.sv
`timescale 1ns/1ps
// fifo_ptr_sync
// Multi-flop synchroniser for a gray-coded FIFO pointer. It is reset by the
// destination domain.
//   clk  - destination clock
//   rstn - destination reset, asynchronous, active-low
//   d    - gray pointer from the source domain (registered there)
//   q    - synchronised pointer, STAGES destination cycles later
module fifo_ptr_sync #(
    parameter int W      = 5,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // stage_reg[0] samples the asynchronous input. Later stages let any
    // metastability resolve.
    logic [STAGES-1:0][W-1:0] stage_reg;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stage_reg <= '0;
        end else begin
            stage_reg <= {stage_reg[STAGES-2:0], d};
        end
    end

    assign q = stage_reg[STAGES-1];

endmodule

// File: rtl/asyn_fifo_lvl.sv
`timescale 1ns/1ps
// asyn_fifo_lvl
// Dual-clock FIFO with gray-pointer crossing and a configurable synchroniser
// depth. It reports the fill level in each domain and has programmable
// almost-full and almost-empty flags. It also has a read-valid strobe and
// sticky overflow and underflow flags.
//   Write domain (wclk / wrstn): winc, wdata, wfull, almost_full, wr_level, wovf
//   Read domain  (rclk / rrstn): rinc, rdata, rvalid, rempty, almost_empty,
//                                rd_level, rudf
// Both resets are asynchronous and active-low. Assert both together for a
// clean restart.
module asyn_fifo_lvl
    import asyn_fifo_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int AFULL_TH    = DEPTH - 2,
    parameter int AEMPTY_TH   = 2
) (
    input  logic                     wclk,
    input  logic                     wrstn,
    input  logic                     rclk,
    input  logic                     rrstn,
    input  logic                     winc,
    input  logic [WIDTH-1:0]         wdata,
    output logic                     wfull,
    output logic                     almost_full,
    output logic [$clog2(DEPTH):0]   wr_level,
    output logic                     wovf,
    input  logic                     rinc,
    output logic [WIDTH-1:0]         rdata,
    output logic                     rvalid,
    output logic                     rempty,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   rd_level,
    output logic                     rudf
);

    localparam int PW = ptr_width(DEPTH);
    localparam int AW = PW - 1;

    // ---------------------------------------------------------------- write
    logic [PW-1:0]   wbin_reg, wbin_next;
    logic [PW-1:0]   wgray_reg, wgray_next;
    logic [PW-1:0]   rsync, rsync_bin;
    logic [31-PW:0]  wgray_unused, rsync_bin_unused;
    logic            wovf_reg;
    logic            wen;

    assign wen       = winc & ~wfull;
    assign wbin_next = wbin_reg + PW'(wen);
    assign {wgray_unused, wgray_next}    = bin2gray(32'(wbin_next));
    assign {rsync_bin_unused, rsync_bin} = gray2bin(32'(rsync));

    // The gray pointer is registered from the next binary value, so it flips
    // on the same edge as wbin. The synchroniser then sees a clean flop
    // output that changes by one bit per write.
    always_ff @(posedge wclk or negedge wrstn) begin
        if (!wrstn) begin
            wbin_reg  <= '0;
            wgray_reg <= '0;
            wovf_reg  <= 1'b0;
        end else begin
            wbin_reg  <= wbin_next;
            wgray_reg <= wgray_next;
            if (winc && wfull) begin
                wovf_reg <= 1'b1;
            end
        end
    end

    // The FIFO is full when the writer is exactly one lap ahead. In gray
    // code that means the top two bits are inverted and the rest are equal.
    assign wfull       = (wgray_reg == {~rsync[AW:AW-1], rsync[AW-2:0]});
    assign wr_level    = wbin_reg - rsync_bin;
    assign almost_full = (wr_level >= PW'(AFULL_TH));
    assign wovf        = wovf_reg;

    // ----------------------------------------------------------------- read
    logic [PW-1:0]   rbin_reg, rbin_next;
    logic [PW-1:0]   rgray_reg, rgray_next;
    logic [PW-1:0]   wsync, wsync_bin;
    logic [31-PW:0]  rgray_unused, wsync_bin_unused;
    logic            rvalid_reg, rudf_reg, rdata_seen_reg;
    logic            ren;
    logic [WIDTH-1:0] ram_q;

    assign ren       = rinc & ~rempty;
    assign rbin_next = rbin_reg + PW'(ren);
    assign {rgray_unused, rgray_next}    = bin2gray(32'(rbin_next));
    assign {wsync_bin_unused, wsync_bin} = gray2bin(32'(wsync));

    always_ff @(posedge rclk or negedge rrstn) begin
        if (!rrstn) begin
            rbin_reg       <= '0;
            rgray_reg      <= '0;
            rvalid_reg     <= 1'b0;
            rudf_reg       <= 1'b0;
            rdata_seen_reg <= 1'b0;
        end else begin
            rbin_reg   <= rbin_next;
            rgray_reg  <= rgray_next;
            rvalid_reg <= ren;
            if (ren) begin
                rdata_seen_reg <= 1'b1;
            end
            if (rinc && rempty) begin
                rudf_reg <= 1'b1;
            end
        end
    end

    assign rempty       = (rgray_reg == wsync);
    assign rd_level     = wsync_bin - rbin_reg;
    assign almost_empty = (rd_level <= PW'(AEMPTY_TH));
    assign rvalid       = rvalid_reg;
    assign rudf         = rudf_reg;

    // The RAM output register has no reset, so that it maps onto block RAM.
    // rdata reads as zero until the first accepted read after reset. After
    // that it follows the RAM register, which only changes on ren.
    assign rdata = rdata_seen_reg ? ram_q : '0;

    // ------------------------------------------------------- crossings, RAM
    fifo_ptr_sync #(.W(PW), .STAGES(SYNC_STAGES)) u_rsync (
        .clk  (wclk),
        .rstn (wrstn),
        .d    (rgray_reg),
        .q    (rsync)
    );

    fifo_ptr_sync #(.W(PW), .STAGES(SYNC_STAGES)) u_wsync (
        .clk  (rclk),
        .rstn (rrstn),
        .d    (wgray_reg),
        .q    (wsync)
    );

    dual_port_RAM #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ram (
        .wclk  (wclk),
        .wenc  (wen),
        .waddr (wbin_reg[AW-1:0]),
        .wdata (wdata),
        .rclk  (rclk),
        .renc  (ren),
        .raddr (rbin_reg[AW-1:0]),
        .rdata (ram_q)
    );

endmodule

// File: tb/tb_asyn_fifo_lvl.sv
`timescale 1ns/1ps
// Bench for asyn_fifo_lvl (DEPTH=16, SYNC_STAGES=2, AFULL_TH=14, AEMPTY_TH=2).
// wclk has a 10 ns period and rclk a 17 ns period. Words that should be
// read are pushed to a queue when they are written. A monitor on the read
// side pops the queue and compares on every rvalid.
module tb_asyn_fifo_lvl;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int LW    = 5;

    logic             wclk = 1'b0, rclk = 1'b0;
    logic             wrstn = 1'b0, rrstn = 1'b0;
    logic             winc = 1'b0, rinc = 1'b0;
    logic [WIDTH-1:0] wdata = '0;
    logic             wfull, almost_full, wovf;
    logic [LW-1:0]    wr_level, rd_level;
    logic [WIDTH-1:0] rdata;
    logic             rvalid, rempty, almost_empty, rudf;

    asyn_fifo_lvl #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .SYNC_STAGES(2), .AFULL_TH(14), .AEMPTY_TH(2)
    ) dut (
        .wclk(wclk), .wrstn(wrstn), .rclk(rclk), .rrstn(rrstn),
        .winc(winc), .wdata(wdata), .wfull(wfull), .almost_full(almost_full),
        .wr_level(wr_level), .wovf(wovf),
        .rinc(rinc), .rdata(rdata), .rvalid(rvalid), .rempty(rempty),
        .almost_empty(almost_empty), .rd_level(rd_level), .rudf(rudf)
    );

    always #5   wclk = ~wclk;
    always #8.5 rclk = ~rclk;

    int checks = 0;
    int errors = 0;
    int rx_count = 0;
    int max_wr = 0, max_rd = 0;
    logic [WIDTH-1:0] sb [$];
    logic [WIDTH-1:0] exp_d;

    typedef struct {
        logic             winc;
        logic [WIDTH-1:0] wdata;
        logic             push;
        int               exp_level;
        logic             exp_af;
        logic             exp_full;
        logic             exp_ovf;
    } wvec_t;

    wvec_t fill_tbl [17];

    function automatic void check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endfunction

    // Read-side scoreboard: each rvalid must match the oldest word still owed.
    always @(negedge rclk) begin
        if (rrstn && rvalid) begin
            if (sb.size() == 0) begin
                check("rvalid_unexpected", 1, 0);
            end else begin
                exp_d = sb.pop_front();
                check("rdata", int'(rdata), int'(exp_d));
                $display("read %0d data=%02h expected=%02h", rx_count, rdata, exp_d);
            end
            rx_count++;
        end
        if (int'(rd_level) > max_rd) max_rd = int'(rd_level);
    end

    always @(negedge wclk) begin
        if (int'(wr_level) > max_wr) max_wr = int'(wr_level);
    end

    task automatic check_reset_state(input string tag);
        check({tag, "_wfull"},        int'(wfull),        0);
        check({tag, "_almost_full"},  int'(almost_full),  0);
        check({tag, "_wr_level"},     int'(wr_level),     0);
        check({tag, "_wovf"},         int'(wovf),         0);
        check({tag, "_rempty"},       int'(rempty),       1);
        check({tag, "_almost_empty"}, int'(almost_empty), 1);
        check({tag, "_rd_level"},     int'(rd_level),     0);
        check({tag, "_rvalid"},       int'(rvalid),       0);
        check({tag, "_rudf"},         int'(rudf),         0);
        check({tag, "_rdata"},        int'(rdata),        0);
    endtask

    task automatic do_reset();
        winc  = 1'b0;
        rinc  = 1'b0;
        wrstn = 1'b0;
        rrstn = 1'b0;
        #37;
        sb.delete();
        wrstn = 1'b1;
        rrstn = 1'b1;
        repeat (3) @(posedge rclk);
        #1;
    endtask

    task automatic write_word(input logic [WIDTH-1:0] d, input logic push);
        @(negedge wclk);
        winc  = 1'b1;
        wdata = d;
        if (push) sb.push_back(d);
        @(negedge wclk);
        winc  = 1'b0;
    endtask

    task automatic read_one();
        @(negedge rclk);
        rinc = 1'b1;
        @(posedge rclk);
        #1;
        rinc = 1'b0;
        repeat (2) @(posedge rclk);
        #1;
    endtask

    initial begin
        int found;
        int base;

        // Fill table. With no reads the writer's view is exact, so the level
        // equals the number of accepted writes. The 17th request hits a full
        // FIFO.
        for (int i = 0; i < 17; i++) begin
            fill_tbl[i].winc      = 1'b1;
            fill_tbl[i].wdata     = (i < 16) ? 8'(i) : 8'hEE;
            fill_tbl[i].push      = (i < 16);
            fill_tbl[i].exp_level = (i < 16) ? i + 1 : 16;
            fill_tbl[i].exp_af    = ((i + 1) >= 14);
            fill_tbl[i].exp_full  = (i >= 15);
            fill_tbl[i].exp_ovf   = (i == 16);
        end

        // Reset state
        #23;
        check_reset_state("in_reset");
        do_reset();
        check_reset_state("after_reset");

        // Fill to full, then overflow
        for (int i = 0; i < 17; i++) begin
            @(negedge wclk);
            winc  = fill_tbl[i].winc;
            wdata = fill_tbl[i].wdata;
            if (fill_tbl[i].push) sb.push_back(fill_tbl[i].wdata);
            @(posedge wclk);
            #1;
            check("fill_wr_level",    int'(wr_level),    fill_tbl[i].exp_level);
            check("fill_almost_full", int'(almost_full), int'(fill_tbl[i].exp_af));
            check("fill_wfull",       int'(wfull),       int'(fill_tbl[i].exp_full));
            check("fill_wovf",        int'(wovf),        int'(fill_tbl[i].exp_ovf));
            $display("write %0d data=%02h level=%0d full=%0d", i, wdata, wr_level, wfull);
        end
        @(negedge wclk);
        winc = 1'b0;
        repeat (4) @(posedge rclk);
        #1;
        check("full_rd_level",     int'(rd_level),     16);
        check("full_almost_empty", int'(almost_empty), 0);
        check("full_rempty",       int'(rempty),       0);

        // Drain all 16, then underflow
        @(negedge rclk);
        rinc = 1'b1;
        repeat (16) @(posedge rclk);
        #1;
        rinc = 1'b0;
        check("drain_rempty", int'(rempty), 1);
        repeat (2) @(posedge rclk);
        #1;
        check("drain_rx_count", rx_count, 16);
        check("drain_sb_empty", sb.size(), 0);
        @(negedge rclk);
        rinc = 1'b1;
        @(posedge rclk);
        #1;
        rinc = 1'b0;
        check("udf_rudf",   int'(rudf),   1);
        check("udf_rvalid", int'(rvalid), 0);
        check("udf_rdata",  int'(rdata),  8'h0F);
        check("udf_wovf_sticky", int'(wovf), 1);

        // Single write into an empty FIFO
        do_reset();
        @(negedge wclk);
        winc  = 1'b1;
        wdata = 8'hA5;
        sb.push_back(8'hA5);
        @(posedge wclk);
        fork
            begin #1; winc = 1'b0; end
        join_none
        found = 0;
        for (int k = 0; k < 3; k++) begin
            @(posedge rclk);
            #1;
            if (!rempty) begin
                found = 1;
                break;
            end
        end
        check("single_rempty_fall",   found,              1);
        check("single_rd_level",      int'(rd_level),     1);
        check("single_almost_empty",  int'(almost_empty), 1);
        read_one();
        check("single_rx_count", rx_count, 17);
        check("single_rdata",    int'(rdata), 8'hA5);

        // Concurrent stream of 100 words
        base   = rx_count;
        max_wr = 0;
        max_rd = 0;
        fork
            begin
                int n = 0;
                int t = 0;
                while (n < 100 && t < 5000) begin
                    @(negedge wclk);
                    t++;
                    if (!wfull) begin
                        winc  = 1'b1;
                        wdata = 8'(n);
                        sb.push_back(8'(n));
                        n++;
                    end else begin
                        winc = 1'b0;
                    end
                end
                @(negedge wclk);
                winc = 1'b0;
            end
            begin
                int t = 0;
                while (rx_count < base + 100 && t < 5000) begin
                    @(negedge rclk);
                    t++;
                    rinc = !rempty && ($urandom_range(0, 3) != 0);
                end
                rinc = 1'b0;
            end
        join
        repeat (2) @(posedge rclk);
        #1;
        check("stream_rx_count",  rx_count - base, 100);
        check("stream_sb_empty",  sb.size(), 0);
        check("stream_wovf",      int'(wovf), 0);
        check("stream_rudf",      int'(rudf), 0);
        check("stream_max_wr_ok", int'(max_wr <= 16), 1);
        check("stream_max_rd_ok", int'(max_rd <= 16), 1);

        // Reset with 9 words stored
        for (int i = 0; i < 9; i++) begin
            write_word(8'(8'h50 + i), 1'b0);
        end
        repeat (4) @(posedge rclk);
        #1;
        check("mid_rd_level", int'(rd_level), 9);
        check("mid_wr_level", int'(wr_level), 9);
        @(negedge wclk);
        wrstn = 1'b0;
        rrstn = 1'b0;
        #3;
        check_reset_state("mid_in_reset");
        #20;
        wrstn = 1'b1;
        rrstn = 1'b1;
        repeat (3) @(posedge rclk);
        #1;
        check_reset_state("mid_after_reset");
        base = rx_count;
        write_word(8'h3C, 1'b1);
        repeat (4) @(posedge rclk);
        #1;
        check("restart_rd_level", int'(rd_level), 1);
        read_one();
        check("restart_rx_count", rx_count - base, 1);
        check("restart_rdata",    int'(rdata), 8'h3C);
        check("restart_rempty",   int'(rempty), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
